// File: rtl/la_trigger_ctrl.sv
// Logic-analyzer trigger conditioner: synchronizes and qualifies a selectable
// trigger source, applies a programmable delay and emits a stretched capture pulse.
module la_trigger_ctrl #(
   parameter int         pBYTECNT_SIZE = 7,
   parameter logic [7:0] pADDR_CTRL    = 8'h70,
   parameter logic [7:0] pADDR_PATTERN = 8'h71,
   parameter logic [7:0] pADDR_DELAY   = 8'h72,
   parameter logic [7:0] pADDR_WIDTH   = 8'h73,
   parameter logic [7:0] pADDR_STATUS  = 8'h74
) (
   input  logic                     clk_usb,
   input  logic                     reset,
   input  logic [7:0]               reg_address,
   input  logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
   input  logic [7:0]               reg_datai,
   output logic [7:0]               reg_datao,
   input  logic                     reg_read,
   input  logic                     reg_write,
   input  logic                     glitch_go,
   input  logic                     adc_capture_go,
   input  logic [7:0]               userio,
   output logic                     capture_go_async,
   output logic                     armed
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARMED = 3'd1,
      ST_DELAY = 3'd2,
      ST_FIRE  = 3'd3
   } state_t;

   state_t      r_state;
   state_t      w_next_state;

   logic        r_auto_rearm;
   logic        r_pol;
   logic [1:0]  r_src;
   logic [7:0]  r_pat_value;
   logic [7:0]  r_pat_mask;
   logic [15:0] r_delay_cfg;
   logic [7:0]  r_width_cfg;
   logic [15:0] r_delay_wk;
   logic [7:0]  r_width_wk;
   logic [15:0] r_delay_cnt;
   logic [7:0]  r_width_cnt;
   logic [7:0]  r_trig_count;
   logic [9:0]  r_sync1;
   logic [9:0]  r_sync2;
   logic [9:0]  r_prev;
   logic        r_event;
   logic        r_fire;
   logic        r_capture;
   logic        r_armed;
   logic [7:0]  r_datao;

   logic        w_byte0;
   logic        w_byte1;
   logic        w_wr_ctrl;
   logic        w_arm;
   logic        w_disarm;
   logic        w_match_now;
   logic        w_match_prev;
   logic        w_sel_now;
   logic        w_sel_prev;
   logic        w_event;
   logic        w_trig;
   logic [7:0]  w_width_load;
   logic [7:0]  w_rd_data;
   logic        w_unused_ok;

   assign w_byte0      = (reg_bytecnt == pBYTECNT_SIZE'(0));
   assign w_byte1      = (reg_bytecnt == pBYTECNT_SIZE'(1));
   assign w_wr_ctrl    = reg_write && (reg_address == pADDR_CTRL) && w_byte0;
   assign w_arm        = w_wr_ctrl && reg_datai[0];
   assign w_disarm     = w_wr_ctrl && !reg_datai[0];
   assign w_match_now  = (((r_sync2[9:2] ^ r_pat_value) & r_pat_mask) == 8'h00);
   assign w_match_prev = (((r_prev[9:2] ^ r_pat_value) & r_pat_mask) == 8'h00);
   assign w_event      = r_pol ? (w_sel_prev & ~w_sel_now) : (w_sel_now & ~w_sel_prev);
   assign w_trig       = r_event | r_fire;
   assign w_width_load = (r_width_wk == 8'd0) ? 8'd1 : r_width_wk;
   assign w_unused_ok  = ^reg_datai[7:6];

   // Source selection; src 3 is manual-only and never produces an edge event
   always_comb begin
      w_sel_now  = 1'b0;
      w_sel_prev = 1'b0;
      case (r_src)
         2'd0: begin
            w_sel_now  = r_sync2[0];
            w_sel_prev = r_prev[0];
         end
         2'd1: begin
            w_sel_now  = r_sync2[1];
            w_sel_prev = r_prev[1];
         end
         2'd2: begin
            w_sel_now  = w_match_now;
            w_sel_prev = w_match_prev;
         end
         default: begin
            w_sel_now  = 1'b0;
            w_sel_prev = 1'b0;
         end
      endcase
   end

   // Input synchronizers, history stage, and registered trigger requests
   always_ff @(posedge clk_usb) begin
      if (reset) begin
         r_sync1 <= 10'd0;
         r_sync2 <= 10'd0;
         r_prev  <= 10'd0;
         r_event <= 1'b0;
         r_fire  <= 1'b0;
      end else begin
         r_sync1 <= {userio, adc_capture_go, glitch_go};
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
         r_event <= w_event;
         r_fire  <= w_wr_ctrl & reg_datai[5];
      end
   end

   // Next-state logic; a disarm write overrides everything else
   always_comb begin
      w_next_state = r_state;
      if (w_disarm) begin
         w_next_state = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_arm) w_next_state = ST_ARMED;
               else       w_next_state = ST_IDLE;
            end
            ST_ARMED: begin
               if (w_trig) begin
                  if (r_delay_wk == 16'd0) w_next_state = ST_FIRE;
                  else                     w_next_state = ST_DELAY;
               end else begin
                  w_next_state = ST_ARMED;
               end
            end
            ST_DELAY: begin
               if (r_delay_cnt == 16'd1) w_next_state = ST_FIRE;
               else                      w_next_state = ST_DELAY;
            end
            ST_FIRE: begin
               if (r_width_cnt == 8'd1) begin
                  if (r_auto_rearm) w_next_state = ST_ARMED;
                  else              w_next_state = ST_IDLE;
               end else begin
                  w_next_state = ST_FIRE;
               end
            end
            default: w_next_state = ST_IDLE;
         endcase
      end
   end

   // State register, delay/width counters, trigger counter and registered outputs
   always_ff @(posedge clk_usb) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_capture    <= 1'b0;
         r_armed      <= 1'b0;
         r_delay_wk   <= 16'd0;
         r_width_wk   <= 8'd0;
         r_delay_cnt  <= 16'd0;
         r_width_cnt  <= 8'd0;
         r_trig_count <= 8'd0;
      end else begin
         r_state   <= w_next_state;
         r_capture <= (w_next_state == ST_FIRE);
         r_armed   <= (w_next_state == ST_ARMED);
         // Working copies are frozen at arm time so later config writes can't disturb a trigger in flight
         if ((r_state == ST_IDLE) && w_arm) begin
            r_delay_wk   <= r_delay_cfg;
            r_width_wk   <= r_width_cfg;
            r_trig_count <= 8'd0;
         end
         if ((r_state == ST_ARMED) && (w_next_state == ST_DELAY)) begin
            r_delay_cnt <= r_delay_wk;
         end else if (r_state == ST_DELAY) begin
            r_delay_cnt <= r_delay_cnt - 16'd1;
         end
         if ((r_state != ST_FIRE) && (w_next_state == ST_FIRE)) begin
            r_width_cnt <= w_width_load;
            if (r_trig_count != 8'hFF) r_trig_count <= r_trig_count + 8'd1;
         end else if (r_state == ST_FIRE) begin
            r_width_cnt <= r_width_cnt - 8'd1;
         end
      end
   end

   // Configuration register writes
   always_ff @(posedge clk_usb) begin
      if (reset) begin
         r_auto_rearm <= 1'b0;
         r_src        <= 2'd0;
         r_pol        <= 1'b0;
         r_pat_value  <= 8'h00;
         r_pat_mask   <= 8'h00;
         r_delay_cfg  <= 16'd0;
         r_width_cfg  <= 8'd0;
      end else if (reg_write) begin
         case (reg_address)
            pADDR_CTRL: begin
               if (w_byte0) begin
                  r_auto_rearm <= reg_datai[1];
                  r_src        <= reg_datai[3:2];
                  r_pol        <= reg_datai[4];
               end
            end
            pADDR_PATTERN: begin
               if (w_byte0)      r_pat_value <= reg_datai;
               else if (w_byte1) r_pat_mask  <= reg_datai;
            end
            pADDR_DELAY: begin
               if (w_byte0)      r_delay_cfg[7:0]  <= reg_datai;
               else if (w_byte1) r_delay_cfg[15:8] <= reg_datai;
            end
            pADDR_WIDTH: begin
               if (w_byte0) r_width_cfg <= reg_datai;
            end
            default: begin
            end
         endcase
      end
   end

   // Read mux; anything unmapped or out of range returns zero
   always_comb begin
      w_rd_data = 8'h00;
      case (reg_address)
         pADDR_CTRL: begin
            if (w_byte0) w_rd_data = {3'b000, r_pol, r_src, r_auto_rearm, (r_state != ST_IDLE)};
            else         w_rd_data = 8'h00;
         end
         pADDR_PATTERN: begin
            if (w_byte0)      w_rd_data = r_pat_value;
            else if (w_byte1) w_rd_data = r_pat_mask;
            else              w_rd_data = 8'h00;
         end
         pADDR_DELAY: begin
            if (w_byte0)      w_rd_data = r_delay_cfg[7:0];
            else if (w_byte1) w_rd_data = r_delay_cfg[15:8];
            else              w_rd_data = 8'h00;
         end
         pADDR_WIDTH: begin
            if (w_byte0) w_rd_data = r_width_cfg;
            else         w_rd_data = 8'h00;
         end
         pADDR_STATUS: begin
            if (w_byte0)      w_rd_data = {5'b00000, r_state};
            else if (w_byte1) w_rd_data = r_trig_count;
            else              w_rd_data = 8'h00;
         end
         default: w_rd_data = 8'h00;
      endcase
   end

   // Registered read data, zero whenever no read is in progress
   always_ff @(posedge clk_usb) begin
      if (reset) r_datao <= 8'h00;
      else       r_datao <= reg_read ? w_rd_data : 8'h00;
   end

   assign reg_datao        = r_datao;
   assign capture_go_async = r_capture;
   assign armed            = r_armed;

endmodule

// File: tb/tb_la_trigger_ctrl.sv
// Self-checking bench for la_trigger_ctrl: randomized scenarios checked against
// trigger timing computed from the source edge, delay and width rules.
module tb_la_trigger_ctrl;

   logic       clk_usb = 1'b0;
   logic       reset;
   logic [7:0] reg_address;
   logic [6:0] reg_bytecnt;
   logic [7:0] reg_datai;
   logic [7:0] reg_datao;
   logic       reg_read;
   logic       reg_write;
   logic       glitch_go;
   logic       adc_capture_go;
   logic [7:0] userio;
   logic       capture_go_async;
   logic       armed;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int starts[$];
   int lens[$];
   int cur_start = 0;
   logic prev_cap = 1'b0;

   always #5 clk_usb = ~clk_usb;

   la_trigger_ctrl dut (
      .clk_usb(clk_usb), .reset(reset), .reg_address(reg_address),
      .reg_bytecnt(reg_bytecnt), .reg_datai(reg_datai), .reg_datao(reg_datao),
      .reg_read(reg_read), .reg_write(reg_write), .glitch_go(glitch_go),
      .adc_capture_go(adc_capture_go), .userio(userio),
      .capture_go_async(capture_go_async), .armed(armed)
   );

   always @(posedge clk_usb) cyc <= cyc + 1;

   // Pulse monitor: start edge number and length of every capture pulse
   always @(negedge clk_usb) begin
      if (capture_go_async === 1'b1 && prev_cap !== 1'b1) begin
         starts.push_back(cyc);
         cur_start = cyc;
      end
      if (capture_go_async !== 1'b1 && prev_cap === 1'b1) lens.push_back(cyc - cur_start);
      prev_cap = capture_go_async;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic bit tb_match(input logic [7:0] u, input logic [7:0] v, input logic [7:0] m);
      return ((u ^ v) & m) == 8'h00;
   endfunction

   task automatic idle(input int n);
      repeat (n) @(negedge clk_usb);
   endtask

   task automatic wr(input logic [7:0] a, input int b, input logic [7:0] d);
      reg_address = a; reg_bytecnt = 7'(b); reg_datai = d; reg_write = 1'b1;
      @(negedge clk_usb);
      reg_write = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, input int b, output logic [7:0] d);
      reg_address = a; reg_bytecnt = 7'(b); reg_read = 1'b1;
      @(negedge clk_usb);
      d = reg_datao; reg_read = 1'b0;
   endtask

   task automatic test_reset();
      logic [7:0] d;
      reset = 1'b1; idle(3); reset = 1'b0; idle(1);
      total++; if (capture_go_async !== 1'b0) begin bad++; $display("FAIL reset_cap got=%b exp=0", capture_go_async); end
      total++; if (armed !== 1'b0) begin bad++; $display("FAIL reset_armed got=%b exp=0", armed); end
      total++; if (reg_datao !== 8'h00) begin bad++; $display("FAIL reset_datao got=%h exp=00", reg_datao); end
      rd(8'h74, 0, d);
      total++; if (d !== 8'h00) begin bad++; $display("FAIL reset_state got=%h exp=00", d); end
      rd(8'h74, 1, d);
      total++; if (d !== 8'h00) begin bad++; $display("FAIL reset_count got=%h exp=00", d); end
      rd(8'h70, 0, d);
      total++; if (d !== 8'h00) begin bad++; $display("FAIL reset_ctrl got=%h exp=00", d); end
   endtask

   task automatic test_src0();
      logic [7:0] d;
      int dl, w, n, expl, s0, l0;
      for (int it = 0; it < 3; it++) begin
         dl = (it == 0) ? 0 : int'($urandom_range(1, 12));
         w  = (it == 0) ? 4 : int'($urandom_range(0, 6));
         expl = (w == 0) ? 1 : w;
         glitch_go = 1'b0;
         wr(8'h72, 0, 8'(dl)); wr(8'h72, 1, 8'h00); wr(8'h73, 0, 8'(w)); wr(8'h70, 0, 8'h01);
         idle(4); starts.delete(); lens.delete();
         glitch_go = 1'b1; n = cyc + 1;
         idle(dl + expl + 10);
         s0 = (starts.size() > 0) ? starts[0] : -1;
         l0 = (lens.size() > 0) ? lens[0] : -1;
         total++; if (starts.size() != 1 || s0 != n + 3 + dl) begin bad++; $display("FAIL src0_start it=%0d got=%0d n=%0d exp=%0d", it, s0, starts.size(), n + 3 + dl); end
         total++; if (l0 != expl) begin bad++; $display("FAIL src0_len it=%0d got=%0d exp=%0d", it, l0, expl); end
         rd(8'h74, 0, d);
         total++; if (d !== 8'h00) begin bad++; $display("FAIL src0_state it=%0d got=%h exp=00", it, d); end
         rd(8'h74, 1, d);
         total++; if (d !== 8'h01) begin bad++; $display("FAIL src0_count it=%0d got=%h exp=01", it, d); end
         rd(8'h72, 0, d);
         total++; if (d !== 8'(dl)) begin bad++; $display("FAIL src0_delay_rb it=%0d got=%h exp=%h", it, d, 8'(dl)); end
      end
   endtask

   task automatic test_src1_delay();
      logic [7:0] d;
      int n, s0;
      adc_capture_go = 1'b1;
      wr(8'h72, 0, 8'd100); wr(8'h72, 1, 8'h00); wr(8'h73, 0, 8'd1); wr(8'h70, 0, 8'h15);
      idle(4); starts.delete(); lens.delete();
      adc_capture_go = 1'b0; n = cyc + 1;
      idle(30); adc_capture_go = 1'b1; idle(5); adc_capture_go = 1'b0;
      idle(100);
      s0 = (starts.size() > 0) ? starts[0] : -1;
      total++; if (starts.size() != 1 || s0 != n + 103) begin bad++; $display("FAIL src1_start got=%0d n=%0d exp=%0d", s0, starts.size(), n + 103); end
      rd(8'h74, 1, d);
      total++; if (d !== 8'h01) begin bad++; $display("FAIL src1_count got=%h exp=01", d); end
      rd(8'h74, 0, d);
      total++; if (d !== 8'h00) begin bad++; $display("FAIL src1_state got=%h exp=00", d); end
   endtask

   task automatic test_pattern();
      logic [7:0] val, msk, u0, d;
      logic [7:0] seq [8];
      int len, dl, w, hold, s;
      bit pm;
      int exp_q[$];
      for (int it = 0; it < 2; it++) begin
         if (it == 0) begin
            val = 8'hA5; msk = 8'hF0; u0 = 8'h00; len = 3; dl = 0; w = 2;
            seq[0] = 8'hA3; seq[1] = 8'h00; seq[2] = 8'hAF;
         end else begin
            val = 8'($urandom); msk = 8'($urandom_range(1, 255)); u0 = 8'($urandom);
            len = 8; dl = int'($urandom_range(0, 4)); w = int'($urandom_range(1, 3));
            for (int i = 0; i < 8; i++) begin
               if ($urandom_range(0, 1) == 1) seq[i] = val ^ (8'($urandom) & ~msk);
               else seq[i] = 8'($urandom);
            end
         end
         hold = dl + w + 8;
         userio = u0;
         wr(8'h71, 0, val); wr(8'h71, 1, msk); wr(8'h72, 0, 8'(dl)); wr(8'h72, 1, 8'h00);
         wr(8'h73, 0, 8'(w)); wr(8'h70, 0, 8'h0B);
         idle(4); starts.delete(); lens.delete(); exp_q.delete();
         pm = tb_match(u0, val, msk);
         for (int i = 0; i < len; i++) begin
            userio = seq[i];
            if (tb_match(seq[i], val, msk) && !pm) exp_q.push_back(cyc + 1 + 3 + dl);
            pm = tb_match(seq[i], val, msk);
            idle(hold);
         end
         total++; if (starts.size() != exp_q.size()) begin bad++; $display("FAIL pat_num it=%0d got=%0d exp=%0d", it, starts.size(), exp_q.size()); end
         for (int i = 0; i < exp_q.size(); i++) begin
            s = (i < starts.size()) ? starts[i] : -1;
            total++; if (s != exp_q[i]) begin bad++; $display("FAIL pat_start it=%0d idx=%0d got=%0d exp=%0d", it, i, s, exp_q[i]); end
         end
         total++; if (armed !== 1'b1) begin bad++; $display("FAIL pat_armed it=%0d got=%b exp=1", it, armed); end
         rd(8'h74, 1, d);
         total++; if (d !== 8'(exp_q.size())) begin bad++; $display("FAIL pat_count it=%0d got=%h exp=%h", it, d, 8'(exp_q.size())); end
         rd(8'h71, 2, d);
         total++; if (d !== 8'h00) begin bad++; $display("FAIL pat_oob it=%0d got=%h exp=00", it, d); end
         wr(8'h70, 0, 8'h00); idle(2);
      end
   endtask

   task automatic test_manual();
      logic [7:0] d;
      int w, m, s0, l0;
      w = int'($urandom_range(1, 4));
      wr(8'h72, 0, 8'h00); wr(8'h72, 1, 8'h00); wr(8'h73, 0, 8'(w)); idle(2);
      starts.delete(); lens.delete();
      wr(8'h70, 0, 8'h2C); idle(8);
      total++; if (starts.size() != 0) begin bad++; $display("FAIL man_idle got=%0d pulses exp=0", starts.size()); end
      wr(8'h70, 0, 8'h0D); idle(3);
      m = cyc + 1;
      wr(8'h70, 0, 8'h2D); idle(w + 6);
      s0 = (starts.size() > 0) ? starts[0] : -1;
      l0 = (lens.size() > 0) ? lens[0] : -1;
      total++; if (starts.size() != 1 || s0 != m + 1) begin bad++; $display("FAIL man_start got=%0d exp=%0d", s0, m + 1); end
      total++; if (l0 != w) begin bad++; $display("FAIL man_len got=%0d exp=%0d", l0, w); end
      rd(8'h70, 0, d);
      total++; if (d !== 8'h0C) begin bad++; $display("FAIL man_ctrl got=%h exp=0c", d); end
      rd(8'h74, 0, d);
      total++; if (d !== 8'h00) begin bad++; $display("FAIL man_state got=%h exp=00", d); end
   endtask

   task automatic test_disarm();
      logic [7:0] d;
      int n;
      glitch_go = 1'b0;
      wr(8'h72, 0, 8'hE8); wr(8'h72, 1, 8'h03); wr(8'h73, 0, 8'd2); wr(8'h70, 0, 8'h01);
      idle(4); starts.delete(); lens.delete();
      glitch_go = 1'b1; n = cyc + 1;
      idle(100);
      rd(8'h74, 0, d);
      total++; if (d !== 8'h02) begin bad++; $display("FAIL dis_delay_state got=%h exp=02", d); end
      while (cyc < n + 3 + 499) @(negedge clk_usb);
      wr(8'h70, 0, 8'h00); idle(1100);
      total++; if (starts.size() != 0) begin bad++; $display("FAIL dis_mid got=%0d pulses exp=0", starts.size()); end
      rd(8'h74, 0, d);
      total++; if (d !== 8'h00) begin bad++; $display("FAIL dis_mid_state got=%h exp=00", d); end
      glitch_go = 1'b0;
      wr(8'h72, 0, 8'h00); wr(8'h72, 1, 8'h00); wr(8'h70, 0, 8'h01);
      idle(4); starts.delete(); lens.delete();
      glitch_go = 1'b1; idle(3);
      wr(8'h70, 0, 8'h00); idle(20);
      total++; if (starts.size() != 0) begin bad++; $display("FAIL dis_coincide got=%0d pulses exp=0", starts.size()); end
      rd(8'h74, 0, d);
      total++; if (d !== 8'h00) begin bad++; $display("FAIL dis_coincide_state got=%h exp=00", d); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] d;
      logic [7:0] ra [8];
      int rb [8];
      int k;
      ra = '{8'h70, 8'h71, 8'h71, 8'h72, 8'h72, 8'h73, 8'h74, 8'h74};
      rb = '{0, 0, 1, 0, 1, 0, 0, 1};
      glitch_go = 1'b0;
      wr(8'h71, 0, 8'h5A); wr(8'h71, 1, 8'h3C); wr(8'h72, 0, 8'h00); wr(8'h72, 1, 8'h00);
      wr(8'h73, 0, 8'd50); wr(8'h70, 0, 8'h03); idle(4);
      glitch_go = 1'b1;
      k = 0;
      while (k < 20 && capture_go_async !== 1'b1) begin @(negedge clk_usb); k++; end
      total++; if (capture_go_async !== 1'b1) begin bad++; $display("FAIL rst_fire_timeout got=%b exp=1", capture_go_async); end
      idle(5);
      reset = 1'b1; @(negedge clk_usb);
      total++; if (capture_go_async !== 1'b0) begin bad++; $display("FAIL rst_cap got=%b exp=0", capture_go_async); end
      total++; if (armed !== 1'b0) begin bad++; $display("FAIL rst_armed got=%b exp=0", armed); end
      reset = 1'b0; glitch_go = 1'b0; idle(3);
      for (int i = 0; i < 8; i++) begin
         rd(ra[i], rb[i], d);
         total++; if (d !== 8'h00) begin bad++; $display("FAIL rst_reg addr=%h byte=%0d got=%h exp=00", ra[i], rb[i], d); end
      end
      rd(8'h55, 0, d);
      total++; if (d !== 8'h00) begin bad++; $display("FAIL rst_unmapped got=%h exp=00", d); end
      idle(1);
      total++; if (reg_datao !== 8'h00) begin bad++; $display("FAIL rst_noread got=%h exp=00", reg_datao); end
   endtask

   initial begin
      reset = 1'b1; reg_address = 8'h00; reg_bytecnt = 7'd0; reg_datai = 8'h00;
      reg_read = 1'b0; reg_write = 1'b0; glitch_go = 1'b0; adc_capture_go = 1'b0; userio = 8'h00;
      @(negedge clk_usb);
      test_reset();
      test_src0();
      test_src1_delay();
      test_pattern();
      test_manual();
      test_disarm();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
